rv32i_multicycle_ctrl: RTL

Multi-cycle control FSM for the RV32I core. It sequences instruction fetch, decode, execute, memory and writeback around the shared datapath (decoder, regfile, ALU, single memory port). It consumes the decoder's opcode, funct3, funct7 and rd fields and the ALU branch condition. It drives all datapath enables and mux selects, and runs the memory request/ready handshake.

---
 rtl/rv32i_multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : rv32i_multicycle_ctrl
// Brief    : Multi-cycle RV32I control FSM; optional perf counters via CTRL_PERF_CNT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module rv32i_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_WIDTH    = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic [4:0] rd_addr_i,
  input  logic       branch_cond_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       addr_sel_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] alu_a_sel_o,
  output logic [1:0] alu_b_sel_o,
  output logic [1:0] result_sel_o,
  output logic       reg_we_o,
  output logic [2:0] state_o,
  output logic       illegal_o,
  output logic       bus_err_o,
  output logic       halted_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] instret_cnt_o
`endif
);

  localparam int c_WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_WAIT_MAX);

  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_I     = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;
  localparam logic [6:0] c_OP_BR    = 7'b1100011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
  localparam logic [6:0] c_OP_SYS   = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  state_t                r_state, w_next;
  logic [c_WAIT_W-1:0]   r_wait;
  logic                  r_illegal, r_bus_err, r_halted;

  logic w_is_r, w_is_i, w_is_load, w_is_store, w_is_br;
  logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_is_sys, w_legal;
  logic w_wait_expired;
  logic w_mem_req, w_mem_we, w_ir_we, w_pc_we, w_reg_we;
  logic [1:0] w_alu_a, w_alu_b;

  // funct3/funct7 feed ALU control only; the sequencing never depends on them
  logic w_unused;
  assign w_unused = ^{funct3_i, funct7_i};

  assign w_is_r     = (opcode_i == c_OP_R);
  assign w_is_i     = (opcode_i == c_OP_I);
  assign w_is_load  = (opcode_i == c_OP_LOAD);
  assign w_is_store = (opcode_i == c_OP_STORE);
  assign w_is_br    = (opcode_i == c_OP_BR);
  assign w_is_jal   = (opcode_i == c_OP_JAL);
  assign w_is_jalr  = (opcode_i == c_OP_JALR);
  assign w_is_lui   = (opcode_i == c_OP_LUI);
  assign w_is_auipc = (opcode_i == c_OP_AUIPC);
  assign w_is_sys   = (opcode_i == c_OP_SYS);
  assign w_legal    = w_is_r | w_is_i | w_is_load | w_is_store | w_is_br |
                      w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;

  // Reaching the limit still allows a ready on that very cycle to succeed
  assign w_wait_expired = (r_wait == c_WAIT_MAX) && !mem_ready_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: begin
        if (mem_ready_i)         w_next = ST_DECODE;
        else if (w_wait_expired) w_next = ST_TRAP;
      end
      ST_DECODE: begin
        if (w_legal)       w_next = ST_EXEC;
        else if (w_is_sys) w_next = ST_HALT;
        else               w_next = ST_TRAP;
      end
      ST_EXEC: begin
        if (w_is_load || w_is_store) w_next = ST_MEM;
        else if (w_is_br)            w_next = ST_FETCH;
        else                         w_next = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready_i)         w_next = w_is_store ? ST_FETCH : ST_WB;
        else if (w_wait_expired) w_next = ST_TRAP;
      end
      ST_WB:   w_next = ST_FETCH;
      ST_TRAP: w_next = ST_TRAP;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_FETCH;
    endcase
  end

  // ALU operand selection is held from EXEC through MEM/WB so the address/result stays valid
  always_comb begin
    w_alu_a = 2'd0;
    w_alu_b = 2'd0;
    if (w_is_lui)                    w_alu_a = 2'd2;
    else if (w_is_auipc || w_is_jal) w_alu_a = 2'd1;
    if (!(w_is_r || w_is_br))        w_alu_b = 2'd1;
  end

  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    addr_sel_o   = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    pc_src_o     = 2'd0;
    alu_a_sel_o  = 2'd0;
    alu_b_sel_o  = 2'd0;
    result_sel_o = 2'd0;
    w_reg_we     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        w_ir_we   = mem_ready_i;
        w_pc_we   = mem_ready_i;
      end
      ST_EXEC: begin
        alu_a_sel_o = w_alu_a;
        alu_b_sel_o = w_alu_b;
        w_pc_we     = (w_is_br & branch_cond_i) | w_is_jal | w_is_jalr;
        if (w_is_br || w_is_jal) pc_src_o = 2'd1;
        else if (w_is_jalr)      pc_src_o = 2'd2;
      end
      ST_MEM: begin
        w_mem_req   = 1'b1;
        w_mem_we    = w_is_store;
        addr_sel_o  = 1'b1;
        alu_a_sel_o = w_alu_a;
        alu_b_sel_o = w_alu_b;
      end
      ST_WB: begin
        alu_a_sel_o = w_alu_a;
        alu_b_sel_o = w_alu_b;
        w_reg_we    = (rd_addr_i != 5'd0);
        if (w_is_load)                   result_sel_o = 2'd1;
        else if (w_is_jal || w_is_jalr)  result_sel_o = 2'd2;
      end
      default: ;
    endcase
  end

  // Gate every enable with reset so nothing commits while reset is asserted
  assign mem_req_o = w_mem_req & ~rst_i;
  assign mem_we_o  = w_mem_we  & ~rst_i;
  assign ir_we_o   = w_ir_we   & ~rst_i;
  assign pc_we_o   = w_pc_we   & ~rst_i;
  assign reg_we_o  = w_reg_we  & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_FETCH;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_FETCH || r_state == ST_MEM) && w_next == r_state)
        r_wait <= r_wait + c_WAIT_W'(1);
      else
        r_wait <= '0;
      if (r_state == ST_DECODE && w_next == ST_TRAP) r_illegal <= 1'b1;
      if (r_state == ST_DECODE && w_next == ST_HALT) r_halted  <= 1'b1;
      if ((r_state == ST_FETCH || r_state == ST_MEM) && w_next == ST_TRAP)
        r_bus_err <= 1'b1;
    end
  end

  assign state_o   = r_state;
  assign illegal_o = r_illegal;
  assign bus_err_o = r_bus_err;
  assign halted_o  = r_halted;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_cycle_cnt, r_instret_cnt;
  logic                 w_retire;

  assign w_retire = (r_state == ST_WB) ||
                    (r_state == ST_MEM && w_is_store && mem_ready_i) ||
                    (r_state == ST_EXEC && w_is_br);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != ST_TRAP && r_state != ST_HALT)
        r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
      if (w_retire)
        r_instret_cnt <= r_instret_cnt + CNT_WIDTH'(1);
    end
  end

  assign cycle_cnt_o   = r_cycle_cnt;
  assign instret_cnt_o = r_instret_cnt;
`else
  logic [CNT_WIDTH-1:0] w_cnt_unused;
  assign w_cnt_unused = '0;
`endif

endmodule
`default_nettype wire
